// File: rtl/devices_regs_param_if.sv
// Bus-side access interface for the parametrised device register bank.
// The master drives address/strobes/write data; the slave returns registered read data and error strobes.
interface devices_regs_param_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] address;
    logic              write_en;
    logic              read_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] read_data;
    logic              read_valid;
    logic              addr_err;

    modport master (
        output address, write_en, read_en, data_in,
        input  read_data, read_valid, addr_err
    );

    modport slave (
        input  address, write_en, read_en, data_in,
        output read_data, read_valid, addr_err
    );
endinterface

// File: rtl/devices_regs_param.sv
// Register bank of NUM_REGS x DATA_W registers, each typed RW, RO (hw pass-through) or W1C (sticky hw-set bits).
// Reads return data one cycle after read_en; writes land on the next edge; there is no backpressure.
module devices_regs_param #(
    parameter int                             DATA_W    = 8,
    parameter int                             ADDR_W    = 4,
    parameter int                             NUM_REGS  = 4,
    parameter logic [NUM_REGS-1:0]            RO_MASK   = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS-1:0]            W1C_MASK  = {NUM_REGS{1'b0}},
    parameter logic [NUM_REGS*DATA_W-1:0]     RESET_VAL = {NUM_REGS*DATA_W{1'b0}}
) (
    input  logic                          clk,
    input  logic                          resetb,
    devices_regs_param_if.slave           bus,
    input  logic [NUM_REGS*DATA_W-1:0]    hw_in,
    input  logic [NUM_REGS*DATA_W-1:0]    hw_set,
    output logic [NUM_REGS*DATA_W-1:0]    reg_out,
    output logic                          irq
);

    localparam logic [NUM_REGS-1:0] RW_MASK = ~(RO_MASK | W1C_MASK);

    generate
        if ((RO_MASK & W1C_MASK) != '0) begin : g_mask_overlap
            $error("devices_regs_param: RO_MASK and W1C_MASK overlap");
        end
        if ((2 ** ADDR_W) < NUM_REGS) begin : g_addr_too_narrow
            $error("devices_regs_param: ADDR_W too small for NUM_REGS");
        end
    endgenerate

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0][DATA_W-1:0] rst_val;
    logic [NUM_REGS-1:0][DATA_W-1:0] cur;
    logic [NUM_REGS-1:0][DATA_W-1:0] hw_in_a, hw_set_a;
    logic [DATA_W-1:0]               read_data_q, read_data_d;
    logic                            read_valid_q, read_valid_d;
    logic                            addr_err_q, addr_err_d;
    logic                            irq_q, irq_d;
    logic [DATA_W-1:0]               rd_sel;
    logic                            addr_oor;

    assign hw_in_a  = hw_in;
    assign hw_set_a = hw_set;

    // Zero-extend before comparing so a fully populated address space never flags.
    assign addr_oor = 32'(bus.address) >= NUM_REGS;

    always_comb begin
        cur     = '0;
        rst_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cur[i]     = RO_MASK[i] ? hw_in_a[i] : regs_q[i];
            rst_val[i] = RW_MASK[i] ? RESET_VAL[i*DATA_W +: DATA_W] : '0;
        end
    end

    assign reg_out = cur;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (W1C_MASK[i]) begin
                // Set is OR-ed in after the clear so a simultaneous set wins.
                regs_d[i] = (regs_q[i] &
                             ~((bus.write_en && bus.address == ADDR_W'(i)) ? bus.data_in : '0))
                            | hw_set_a[i];
            end else if (RO_MASK[i]) begin
                regs_d[i] = '0;
            end else if (bus.write_en && bus.address == ADDR_W'(i)) begin
                regs_d[i] = bus.data_in;
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        irq_d  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (bus.address == ADDR_W'(i)) begin
                rd_sel = cur[i];
            end
            if (W1C_MASK[i] && (|regs_q[i])) begin
                irq_d = 1'b1;
            end
        end
    end

    // Out-of-range reads match no index, so rd_sel is already zero.
    assign read_data_d  = bus.read_en ? rd_sel : read_data_q;
    assign read_valid_d = bus.read_en;
    assign addr_err_d   = (bus.read_en || bus.write_en) && addr_oor;

    always_ff @(posedge clk) begin
        if (!resetb) begin
            regs_q       <= rst_val;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            regs_q       <= regs_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
            irq_q        <= irq_d;
        end
    end

    assign bus.read_data  = read_data_q;
    assign bus.read_valid = read_valid_q;
    assign bus.addr_err   = addr_err_q;
    assign irq            = irq_q;

endmodule
